// File: rtl/truth_table_sweeper.sv
// Sweeps in1/in2 through 00,10,01,11 for a 2-input cell, holds each DWELL_CYCLES clocks and captures out1.
// Optional self-check against an expected table is enabled by defining TT_CHECK_EN.
`timescale 1ns/1ps
module truth_table_sweeper #(
  parameter int DWELL_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  input  logic       out1,
  output logic [3:0] truth_table,
  output logic       busy,
  output logic       done
`ifdef TT_CHECK_EN
  ,
  input  logic [3:0] expected,
  output logic       pass,
  output logic       fail,
  output logic [3:0] mismatch
`endif
);

  localparam int             CW     = $clog2(DWELL_CYCLES) + 1;
  localparam logic [CW-1:0]  RELOAD = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, FINISH} state_t;

  state_t        state, state_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          in1_nxt, in2_nxt;
  logic [3:0]    tt_nxt;
  logic          busy_nxt, done_nxt;

  // The sweep index doubles as the table address {in2,in1}.
  function automatic logic [3:0] capture(input logic [3:0] tt, input logic [1:0] i,
                                         input logic b);
    logic [3:0] r;
    r    = tt;
    r[i] = b;
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    in1_nxt   = in1;
    in2_nxt   = in2;
    tt_nxt    = truth_table;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt          = SETTLE;
          idx_nxt            = 2'd0;
          cnt_nxt            = RELOAD;
          {in2_nxt, in1_nxt} = 2'b00;
          tt_nxt             = 4'b0000;
          busy_nxt           = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          tt_nxt = capture(truth_table, idx, out1);
          if (idx != 2'd3) begin
            idx_nxt            = idx + 2'd1;
            {in2_nxt, in1_nxt} = idx + 2'd1;
            cnt_nxt            = RELOAD;
          end else begin
            // Last sample taken: in1/in2 stay at 1,1 through the FINISH cycle.
            state_nxt = FINISH;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end
      FINISH: begin
        state_nxt          = IDLE;
        {in2_nxt, in1_nxt} = 2'b00;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      cnt         <= '0;
      in1         <= 1'b0;
      in2         <= 1'b0;
      truth_table <= 4'b0000;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      in1         <= in1_nxt;
      in2         <= in2_nxt;
      truth_table <= tt_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

`ifdef TT_CHECK_EN
  logic [3:0] exp_q;

  // Verdict lands together with done and holds until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q    <= 4'b0000;
      pass     <= 1'b0;
      fail     <= 1'b0;
      mismatch <= 4'b0000;
    end else if (state == IDLE && start) begin
      exp_q    <= expected;
      pass     <= 1'b0;
      fail     <= 1'b0;
      mismatch <= 4'b0000;
    end else if (done_nxt) begin
      mismatch <= tt_nxt ^ exp_q;
      pass     <= (tt_nxt == exp_q);
      fail     <= (tt_nxt != exp_q);
    end
  end
`endif

endmodule
